// File: rtl/cornice_pkg.sv
// Shared types, screen defaults and integer helpers for the moving framed box.
package cornice_pkg;

  localparam int COORD_W_DEF = 11;
  localparam int H_DEF       = 1280;
  localparam int V_DEF       = 1024;

  typedef logic [COORD_W_DEF-1:0] coord_t;

  typedef enum logic {STOP = 1'b0, MOVE = 1'b1} state_t;

  function automatic int clamp_i(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Single fold into [0, m). Inputs are never more than one period out.
  function automatic int wrap_fold(input int v, input int m);
    if (v < 0)  return v + m;
    if (v >= m) return v - m;
    return v;
  endfunction

  // Shortest signed distance on a ring of size m, range (-m/2, m/2].
  function automatic int half_fold(input int v, input int m);
    if (v > m / 2)   return v - m;
    if (v <= -m / 2) return v + m;
    return v;
  endfunction

endpackage

// File: rtl/box_hit_pipe.sv
// Two-stage box membership test: stage 1 registers signed offsets from the
// centre, stage 2 registers the strict half-size compare.
module box_hit_pipe
  import cornice_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int H       = H_DEF,
  parameter int WRAP_X  = 1,
  parameter int HALF_W  = 50,
  parameter int HALF_H  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [COORD_W-1:0] qx,
  input  logic [COORD_W-1:0] qy,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               valid_out,
  output logic               hit
);

  localparam int AW     = COORD_W + 2;
  localparam int STAGES = 2;

  logic [STAGES:1]      vld_pipe;
  logic signed [AW-1:0] dx_q, dy_q;
  int                   dx_c, dy_c, adx, ady;

  always_comb begin
    dx_c = int'(qx) - int'(px);
    if (WRAP_X != 0) dx_c = half_fold(dx_c, H);
    dy_c = int'(qy) - int'(py);
  end

  always_comb begin
    adx = int'(dx_q);
    ady = int'(dy_q);
    if (adx < 0) adx = -adx;
    if (ady < 0) ady = -ady;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      hit      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], valid_in};
      dx_q     <= AW'(dx_c);
      dy_q     <= AW'(dy_c);
      // Gate with stage-1 valid so the result is 0 whenever valid_out is 0.
      hit      <= vld_pipe[1] && (adx < HALF_W) && (ady < HALF_H);
    end
  end

  assign valid_out = vld_pipe[STAGES];

endmodule

// File: rtl/cornice_mobile.sv
// Moving framed rectangle: per-frame position/velocity update with wrap or
// bounce, plus a pipelined outer/inner/frame hit test for pixel queries.
module cornice_mobile
  import cornice_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int H         = H_DEF,
  parameter int V         = V_DEF,
  parameter int ALTEZZA   = 100,
  parameter int LARGHEZZA = 100,
  parameter int SPESSORE  = 6,
  parameter int VEL_W     = 5,
  parameter int WRAP_X    = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic                    FRAME_TICK,
  input  logic                    LOAD,
  input  logic [COORD_W-1:0]      X_INIT,
  input  logic [COORD_W-1:0]      Y_INIT,
  input  logic signed [VEL_W-1:0] DX_INIT,
  input  logic signed [VEL_W-1:0] DY_INIT,
  input  logic                    VALID_IN,
  input  logic [COORD_W-1:0]      X_CONTROLLO,
  input  logic [COORD_W-1:0]      Y_CONTROLLO,
  output logic                    VALID_OUT,
  output logic                    ESTERNO,
  output logic                    INTERNO,
  output logic                    CONFERMA,
  output logic [COORD_W-1:0]      X_POS,
  output logic [COORD_W-1:0]      Y_POS,
  output logic                    BOUNCE
);

  localparam int X_LO = LARGHEZZA / 2;
  localparam int X_HI = H - 1 - LARGHEZZA / 2;
  localparam int Y_LO = ALTEZZA / 2;
  localparam int Y_HI = V - 1 - ALTEZZA / 2;

  state_t                  state;
  logic [COORD_W-1:0]      x_pos, y_pos;
  logic signed [VEL_W-1:0] dx, dy;
  logic                    bounce;

  int                      nx_c, ny_c, ld_x, ld_y;
  logic signed [VEL_W-1:0] ndx_c, ndy_c;
  logic                    bx_c, by_c;

  // Reflecting the most negative velocity saturates instead of overflowing.
  function automatic logic signed [VEL_W-1:0] neg_sat(input logic signed [VEL_W-1:0] v);
    if (v == {1'b1, {(VEL_W-1){1'b0}}}) return {1'b0, {(VEL_W-1){1'b1}}};
    return -v;
  endfunction

  always_comb begin
    ny_c  = int'(y_pos) + int'(dy);
    ndy_c = dy;
    by_c  = 1'b0;
    if (ny_c < Y_LO) begin
      ny_c  = Y_LO;
      ndy_c = neg_sat(dy);
      by_c  = 1'b1;
    end else if (ny_c > Y_HI) begin
      ny_c  = Y_HI;
      ndy_c = neg_sat(dy);
      by_c  = 1'b1;
    end

    nx_c  = int'(x_pos) + int'(dx);
    ndx_c = dx;
    bx_c  = 1'b0;
    if (WRAP_X != 0) begin
      nx_c = wrap_fold(nx_c, H);
    end else if (nx_c < X_LO) begin
      nx_c  = X_LO;
      ndx_c = neg_sat(dx);
      bx_c  = 1'b1;
    end else if (nx_c > X_HI) begin
      nx_c  = X_HI;
      ndx_c = neg_sat(dx);
      bx_c  = 1'b1;
    end

    ld_y = clamp_i(int'(Y_INIT), Y_LO, Y_HI);
    if (WRAP_X != 0) ld_x = wrap_fold(int'(X_INIT), H);
    else             ld_x = clamp_i(int'(X_INIT), X_LO, X_HI);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= STOP;
      x_pos  <= COORD_W'(H / 2);
      y_pos  <= COORD_W'(V / 2);
      dx     <= '0;
      dy     <= '0;
      bounce <= 1'b0;
    end else begin
      state  <= ENABLE ? MOVE : STOP;
      bounce <= 1'b0;
      if (LOAD) begin
        x_pos <= COORD_W'(ld_x);
        y_pos <= COORD_W'(ld_y);
        dx    <= DX_INIT;
        dy    <= DY_INIT;
      end else if (state == MOVE && FRAME_TICK) begin
        x_pos  <= COORD_W'(nx_c);
        y_pos  <= COORD_W'(ny_c);
        dx     <= ndx_c;
        dy     <= ndy_c;
        bounce <= bx_c | by_c;
      end
    end
  end

  logic out_vld, out_hit, in_vld, in_hit;

  box_hit_pipe #(
    .COORD_W(COORD_W), .H(H), .WRAP_X(WRAP_X),
    .HALF_W(LARGHEZZA / 2), .HALF_H(ALTEZZA / 2)
  ) u_outer (
    .clk(CLK), .rst(RST), .valid_in(VALID_IN),
    .qx(X_CONTROLLO), .qy(Y_CONTROLLO), .px(x_pos), .py(y_pos),
    .valid_out(out_vld), .hit(out_hit)
  );

  box_hit_pipe #(
    .COORD_W(COORD_W), .H(H), .WRAP_X(WRAP_X),
    .HALF_W((LARGHEZZA - SPESSORE) / 2), .HALF_H((ALTEZZA - SPESSORE) / 2)
  ) u_inner (
    .clk(CLK), .rst(RST), .valid_in(VALID_IN),
    .qx(X_CONTROLLO), .qy(Y_CONTROLLO), .px(x_pos), .py(y_pos),
    .valid_out(in_vld), .hit(in_hit)
  );

  assign VALID_OUT = out_vld;
  assign ESTERNO   = out_hit;
  assign INTERNO   = in_hit & in_vld;
  assign CONFERMA  = out_hit & ~(in_hit & in_vld);
  assign X_POS     = x_pos;
  assign Y_POS     = y_pos;
  assign BOUNCE    = bounce;

endmodule

// File: tb/tb_cornice_mobile.sv
// Directed bench for cornice_mobile: hit-test vector table plus motion,
// priority and pipeline/reset sequences.
module tb_cornice_mobile;

  logic              CLK = 1'b0;
  logic              RST, ENABLE, FRAME_TICK, LOAD, VALID_IN;
  logic [10:0]       X_INIT, Y_INIT, X_CONTROLLO, Y_CONTROLLO;
  logic signed [4:0] DX_INIT, DY_INIT;
  logic              VALID_OUT, ESTERNO, INTERNO, CONFERMA, BOUNCE;
  logic [10:0]       X_POS, Y_POS;

  int checks = 0;
  int errors = 0;

  cornice_mobile dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FRAME_TICK(FRAME_TICK), .LOAD(LOAD),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .DX_INIT(DX_INIT), .DY_INIT(DY_INIT),
    .VALID_IN(VALID_IN), .X_CONTROLLO(X_CONTROLLO), .Y_CONTROLLO(Y_CONTROLLO),
    .VALID_OUT(VALID_OUT), .ESTERNO(ESTERNO), .INTERNO(INTERNO), .CONFERMA(CONFERMA),
    .X_POS(X_POS), .Y_POS(Y_POS), .BOUNCE(BOUNCE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   px, py, qx, qy;
    logic e, i, c;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input int x, input int y, input int vx, input int vy);
    X_INIT  = 11'(x);
    Y_INIT  = 11'(y);
    DX_INIT = 5'(vx);
    DY_INIT = 5'(vy);
    LOAD    = 1'b1;
    tick();
    LOAD    = 1'b0;
  endtask

  task automatic frame();
    FRAME_TICK = 1'b1;
    tick();
    FRAME_TICK = 1'b0;
  endtask

  task automatic query(input int qx, input int qy);
    X_CONTROLLO = 11'(qx);
    Y_CONTROLLO = 11'(qy);
    VALID_IN    = 1'b1;
    tick();
    VALID_IN    = 1'b0;
    tick();
  endtask

  int bq[5];
  logic be[5];
  logic bi[5];

  initial begin
    // pos x, pos y, query x, query y, ESTERNO, INTERNO, CONFERMA
    vecs[0]  = '{640, 512, 640, 512, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{640, 512, 592, 512, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{10,  300, 1275, 300, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{10,  300, 59,  300, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{10,  300, 60,  300, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{640, 512, 640, 562, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{640, 512, 640, 465, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1270, 300, 5,  300, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{640, 512, 687, 559, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{640, 512, 686, 558, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1270, 300, 1220, 300, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1270, 300, 1221, 300, 1'b1, 1'b0, 1'b1};

    RST = 1'b1; ENABLE = 1'b0; FRAME_TICK = 1'b0; LOAD = 1'b0; VALID_IN = 1'b0;
    X_INIT = '0; Y_INIT = '0; DX_INIT = '0; DY_INIT = '0;
    X_CONTROLLO = '0; Y_CONTROLLO = '0;
    tick(); tick();
    RST = 1'b0;

    chk("reset_x", int'(X_POS), 640);
    chk("reset_y", int'(Y_POS), 512);
    chk("reset_vld", int'(VALID_OUT), 0);
    chk("reset_ext", int'(ESTERNO), 0);
    chk("reset_bounce", int'(BOUNCE), 0);

    // Reset-state queries before any load
    query(640, 512);
    chk("rst_q0_vld", int'(VALID_OUT), 1);
    chk("rst_q0_ext", int'(ESTERNO), 1);
    chk("rst_q0_int", int'(INTERNO), 1);
    chk("rst_q0_conf", int'(CONFERMA), 0);
    query(592, 512);
    chk("rst_q1_ext", int'(ESTERNO), 1);
    chk("rst_q1_int", int'(INTERNO), 0);
    chk("rst_q1_conf", int'(CONFERMA), 1);

    for (int k = 0; k < 12; k++) begin
      do_load(vecs[k].px, vecs[k].py, 0, 0);
      query(vecs[k].qx, vecs[k].qy);
      chk($sformatf("vec%0d_vld", k), int'(VALID_OUT), 1);
      chk($sformatf("vec%0d_ext", k), int'(ESTERNO), int'(vecs[k].e));
      chk($sformatf("vec%0d_int", k), int'(INTERNO), int'(vecs[k].i));
      chk($sformatf("vec%0d_conf", k), int'(CONFERMA), int'(vecs[k].c));
    end

    // LOAD clamping of Y
    do_load(640, 10, 0, 0);
    chk("clamp_y_lo", int'(Y_POS), 50);
    do_load(640, 1020, 0, 0);
    chk("clamp_y_hi", int'(Y_POS), 973);
    do_load(1500, 500, 0, 0);
    chk("reduce_x", int'(X_POS), 220);

    // Horizontal wrap stepping
    ENABLE = 1'b1;
    tick();
    do_load(1275, 300, 10, 0);
    frame();
    chk("wrap_right_x", int'(X_POS), 5);
    chk("wrap_right_bounce", int'(BOUNCE), 0);
    do_load(3, 300, -8, 0);
    frame();
    chk("wrap_left_x", int'(X_POS), 1275);

    // Vertical bounce at the top edge, then moving away
    do_load(640, 55, 0, -10);
    frame();
    chk("vbounce_y", int'(Y_POS), 50);
    chk("vbounce_pulse", int'(BOUNCE), 1);
    tick();
    chk("vbounce_pulse_end", int'(BOUNCE), 0);
    frame();
    chk("vbounce_next_y", int'(Y_POS), 60);
    chk("vbounce_next_pulse", int'(BOUNCE), 0);

    // Most negative velocity reflects to +15
    do_load(640, 60, 0, -16);
    frame();
    chk("sat_y", int'(Y_POS), 50);
    frame();
    chk("sat_next_y", int'(Y_POS), 65);

    // Bottom edge bounce
    do_load(640, 970, 0, 5);
    frame();
    chk("bot_y", int'(Y_POS), 973);
    chk("bot_pulse", int'(BOUNCE), 1);
    frame();
    chk("bot_next_y", int'(Y_POS), 968);

    // LOAD beats FRAME_TICK in the same cycle
    FRAME_TICK = 1'b1;
    do_load(100, 200, 5, 5);
    FRAME_TICK = 1'b0;
    chk("prio_x", int'(X_POS), 100);
    chk("prio_y", int'(Y_POS), 200);
    chk("prio_bounce", int'(BOUNCE), 0);

    // STOP ignores ticks
    ENABLE = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) frame();
    chk("stop_x", int'(X_POS), 100);
    chk("stop_y", int'(Y_POS), 200);
    ENABLE = 1'b1;
    tick();
    frame();
    chk("resume_x", int'(X_POS), 105);

    // Back-to-back queries, results one per cycle
    ENABLE = 1'b0;
    do_load(640, 512, 0, 0);
    bq = '{640, 592, 690, 689, 700};
    be = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    bi = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    Y_CONTROLLO = 11'd512;
    for (int k = 0; k < 6; k++) begin
      VALID_IN = (k < 5);
      if (k < 5) X_CONTROLLO = 11'(bq[k]);
      tick();
      if (k >= 1) begin
        chk($sformatf("b2b%0d_vld", k - 1), int'(VALID_OUT), 1);
        chk($sformatf("b2b%0d_ext", k - 1), int'(ESTERNO), int'(be[k - 1]));
        chk($sformatf("b2b%0d_int", k - 1), int'(INTERNO), int'(bi[k - 1]));
      end
    end
    VALID_IN = 1'b0;
    tick();
    chk("b2b_tail_vld", int'(VALID_OUT), 0);

    // Reset with two queries in flight
    X_CONTROLLO = 11'd640;
    VALID_IN = 1'b1;
    tick();
    tick();
    VALID_IN = 1'b0;
    RST = 1'b1;
    tick();
    chk("flush_vld", int'(VALID_OUT), 0);
    chk("flush_ext", int'(ESTERNO), 0);
    chk("flush_int", int'(INTERNO), 0);
    RST = 1'b0;
    tick();
    chk("flush_vld_next", int'(VALID_OUT), 0);
    chk("flush_ext_next", int'(ESTERNO), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cornice_mobile.md
Name: cornice_mobile

Overview:
- Moving framed rectangle object for the 1280-wide video pipeline. Holds its own centre position and velocity.
- Advances position once per frame tick. Horizontal motion wraps or bounces; vertical motion bounces.
- Answers per-pixel hit queries through a 2-stage pipeline. Reports outer-box, inner-box and frame (outer and not inner) membership.
- Sits between the frame/timing generator and the colour mux. Generalises the combinational rectangle/frame hit-test with configurable size, thickness, screen size, wrap mode and registered motion.

Parameters:
- COORD_W, 11, width of all coordinate ports
- H, 1280, horizontal screen size (modulus for wrap)
- V, 1024, vertical screen size
- ALTEZZA, 100, outer box height
- LARGHEZZA, 100, outer box width
- SPESSORE, 6, frame thickness; inner box is (ALTEZZA-SPESSORE) x (LARGHEZZA-SPESSORE)
- VEL_W, 5, width of signed velocity per axis
- WRAP_X, 1, 1 = horizontal wrap modulo H; 0 = horizontal bounce

Ports:
- CLK  in  1  pixel clock
- RST  in  1  synchronous reset, active high
- ENABLE  in  1  1 = MOVE state allowed; 0 = STOP
- FRAME_TICK  in  1  one-cycle pulse at frame start (during blanking)
- LOAD  in  1  load position and velocity
- X_INIT  in  COORD_W  centre x to load
- Y_INIT  in  COORD_W  centre y to load
- DX_INIT  in  VEL_W  signed x velocity to load
- DY_INIT  in  VEL_W  signed y velocity to load
- VALID_IN  in  1  pixel query valid
- X_CONTROLLO  in  COORD_W  query pixel x
- Y_CONTROLLO  in  COORD_W  query pixel y
- VALID_OUT  out  1  VALID_IN delayed 2 cycles
- ESTERNO  out  1  query inside outer box
- INTERNO  out  1  query inside inner box
- CONFERMA  out  1  ESTERNO && !INTERNO (on the frame)
- X_POS  out  COORD_W  current centre x
- Y_POS  out  COORD_W  current centre y
- BOUNCE  out  1  one-cycle pulse when any axis bounced on this tick

Behaviour:
- Reset and LOAD clamping:
  - RST: X_POS=H/2, Y_POS=V/2, DX=DY=0, state STOP, all pipeline valids 0, ESTERNO/INTERNO/CONFERMA/VALID_OUT/BOUNCE=0.
  - RST mid-operation flushes the pipeline with no partial outputs.
- State machine:
  - STOP -> MOVE when ENABLE=1. MOVE -> STOP when ENABLE=0. Evaluated every cycle.
  - In STOP, FRAME_TICK is ignored and position holds.
- LOAD:
  - Accepted in either state. Writes X_INIT/Y_INIT/DX_INIT/DY_INIT next cycle.
  - Y_INIT is clamped to [ALTEZZA/2, V-1-ALTEZZA/2].
  - X_INIT is reduced to [0,H-1] if WRAP_X=1, else clamped to [LARGHEZZA/2, H-1-LARGHEZZA/2].
  - LOAD and FRAME_TICK in the same cycle: LOAD wins, no step.
- Step (MOVE and FRAME_TICK), computed in COORD_W+2 signed arithmetic:
  - Vertical: ny=Y+DY. If ny<ALTEZZA/2: Y=ALTEZZA/2, DY=-DY. If ny>V-1-ALTEZZA/2: Y=V-1-ALTEZZA/2, DY=-DY. Otherwise Y=ny.
  - Horizontal, WRAP_X=1: nx=X+DX. If nx<0, nx+=H; if nx>=H, nx-=H. |DX|<H is guaranteed by VEL_W.
  - Horizontal, WRAP_X=0: same bounce rule as vertical, using LARGHEZZA/2.
  - BOUNCE pulses 1 cycle after the tick if either axis reflected.
  - Negating the most negative velocity saturates to the max positive value.
- Hit pipeline:
  - Stage 1 registers dx=(X_CONTROLLO-X_POS) and dy=(Y_CONTROLLO-Y_POS) as signed values. With WRAP_X=1, dx is reduced to (-H/2, H/2].
  - Stage 2 registers the compares:
    - ESTERNO = |dx|<LARGHEZZA/2 && |dy|<ALTEZZA/2 (strict).
    - INTERNO uses (LARGHEZZA-SPESSORE)/2 and (ALTEZZA-SPESSORE)/2.
  - Latency is exactly 2 cycles. Throughput is 1 query per cycle.
  - Outputs are 0 whenever VALID_OUT=0.
  - Stage 1 uses the X_POS/Y_POS value of its own cycle. A step in flight affects only later queries.
- Wrap across both screen edges is handled: a box centred at x=10 or x=H-10 hits pixels on both sides.

Decomposition:
- Package cornice_pkg:
  - coord type (COORD_W)
  - state enum {STOP, MOVE}
  - default sizes (H=1280, V=1024)
  - wrap-reduce and clamp functions
- One sub-module, box_hit_pipe: the 2-stage signed-diff/compare pipeline.
  - Parametrised by half-width and half-height.
  - Instantiated twice (outer, inner).
  - VALID_OUT is taken from the outer instance.

Test Plan:
- Reset check: RST, then query (640,512) -> after 2 cycles VALID_OUT=1, ESTERNO=1, INTERNO=1, CONFERMA=0. Query (592,512), |dx|=48 -> ESTERNO=1, INTERNO=0, CONFERMA=1.
- Wrap hit: LOAD X=10, Y=300 (WRAP_X=1). Query (1275,300) -> ESTERNO=1. Query (59,300) -> ESTERNO=1. Query (60,300) -> 0.
- Horizontal wrap step: LOAD X=1275, DX=+10, ENABLE=1, FRAME_TICK -> X_POS=5, BOUNCE=0. LOAD X=3, DX=-8, tick -> X_POS=1275.
- Vertical bounce: LOAD Y=55, DY=-10, tick -> Y_POS=50, DY=+10, BOUNCE pulses 1 cycle. Next tick -> Y_POS=60.
- Priority/STOP: LOAD and FRAME_TICK together -> loaded values, no step. ENABLE=0 with ticks -> position unchanged.
- Pipeline/reset: back-to-back VALID_IN for 5 cycles -> 5 consecutive VALID_OUT with matching results. Assert RST with 2 queries in flight -> VALID_OUT=0 next cycle, no stale outputs.
